iomem_gpio: RTL and testbench
=============================

IOMEM_GPIO -- requirements
Module: iomem_gpio

Interface
REQ-001 The block SHALL have parameter GPIO_W, default 8, meaning GPIO channel count (1..32).
REQ-002 The block SHALL have parameter BASE_SEL, default 8'h03, meaning the value of iomem_addr_i[31:24] that selects this block.
REQ-003 The block SHALL have parameter DEB_CYCLES, default 16, meaning the input stable-count threshold (2..65535); it is used only when debounce is compiled in.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port arst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port iomem_valid_i, input, 1 bit: bus request.
REQ-007 The block SHALL have port iomem_ready_o, output, 1 bit: bus acknowledge.
REQ-008 The block SHALL have port iomem_wstrb_i, input, 4 bits: byte write strobes; all-zero means read.
REQ-009 The block SHALL have ports iomem_addr_i and iomem_wdata_i, input, 32 bits each.
REQ-010 The block SHALL have port iomem_rdata_o, output, 32 bits: registered read data.
REQ-011 The block SHALL have port gpio_i, input, GPIO_W bits: asynchronous pad inputs.
REQ-012 The block SHALL have ports gpio_o and gpio_oe_o, output, GPIO_W bits each: pad data and pad output enable (1 = drive).
REQ-013 The block SHALL have port irq_o, output, 1 bit: level interrupt.

Function
REQ-014 A request SHALL be accepted when iomem_valid_i=1, iomem_ready_o=0 and addr[31:24]=BASE_SEL; all other requests SHALL be ignored with no response.
REQ-015 An accepted request SHALL produce iomem_ready_o=1 for exactly one cycle, on the cycle after acceptance; ready SHALL never be high on two consecutive cycles.
REQ-016 iomem_rdata_o SHALL be valid while ready=1 and SHALL be 0 otherwise; unused high bits SHALL read 0.
REQ-017 The register map (addr[7:0]) SHALL be: 0x00 OUT (RW), 0x04 DIR (RW, drives gpio_oe_o), 0x08 IN (RO), 0x0C IRQ_EN (RW), 0x10 RISE (RW), 0x14 FALL (RW), 0x18 STATUS (RW1C), 0x1C OUT_SET (WO, reads 0), 0x20 OUT_CLR (WO, reads 0).
REQ-018 Writes SHALL honour each strobe bit per byte lane; lanes beyond GPIO_W SHALL be discarded.
REQ-019 Accesses to unmapped offsets inside the block's window SHALL be acknowledged, with writes discarded and reads returning 0.
REQ-020 gpio_i SHALL pass through a 2-flop synchroniser; IN SHALL reflect the synchronised (or debounced) value, with a latency of 2 cycles before debounce.
REQ-021 STATUS[n] SHALL set on a rising edge of IN[n] when RISE[n]=1 and on a falling edge when FALL[n]=1.
REQ-022 If an edge event and a W1C clear hit the same STATUS bit in the same cycle, set SHALL win.
REQ-023 irq_o SHALL be registered and equal |(STATUS & IRQ_EN), one cycle after STATUS changes.
REQ-024 OUT_SET and OUT_CLR SHALL modify only the addressed bits of OUT; gpio_o SHALL equal OUT at all times, regardless of DIR.

Reset
REQ-025 While arst_i=1, all registers SHALL be 0 and ready, rdata, gpio_o, gpio_oe_o and irq_o SHALL be 0; synchroniser and debounce state SHALL clear.
REQ-026 Reset asserted mid-transaction SHALL abort it with no ready pulse; the first request after deassertion SHALL be serviced normally.
REQ-027 Edges caused by the IN value leaving reset (0 to the pad value) SHALL NOT be suppressed.

Configuration
REQ-028 With IOMEM_GPIO_DEBOUNCE_EN defined, each synchronised input SHALL update IN only after DEB_CYCLES consecutive cycles of a stable differing value; its counter SHALL restart on any glitch.
REQ-029 Without IOMEM_GPIO_DEBOUNCE_EN, IN SHALL equal the synchroniser output and no counter logic SHALL exist.

Structure
REQ-030 Register offset constants and the access-decode typedef SHALL reside in package iomem_gpio_pkg.
REQ-031 The per-channel synchroniser plus debouncer SHALL be sub-module gpio_in_filter, instantiated GPIO_W times.

Verification
REQ-032 Write 0xA5 to OUT, then write 0x0F to DIR -> gpio_o=0xA5, gpio_oe_o=0x0F; a read of 0x00 returns 0xA5 with ready one cycle after valid.
REQ-033 OUT=0xF0, then OUT_SET 0x03, then OUT_CLR 0x80 -> OUT reads 0x73.
REQ-034 RISE=0x01, IRQ_EN=0x01, drive gpio_i[0] from 0 to 1 -> STATUS=0x01 after sync latency and irq_o=1 one cycle later; W1C 0x01 -> irq_o=0.
REQ-035 Coincide a rising edge on bit 0 with a W1C to STATUS bit 0 -> STATUS[0] remains 1.
REQ-036 With debounce compiled in and DEB_CYCLES=4, a 3-cycle pulse on gpio_i[1] -> IN unchanged; a 6-cycle pulse -> IN[1]=1 after 2+4 cycles.
REQ-037 Assert arst_i during a pending write -> no ready pulse and all outputs 0; access address 0x04000000 -> no ready.

Source files
------------

// File: rtl/iomem_gpio_pkg.sv
// iomem_gpio_pkg: register offsets and access decode shared by the GPIO block
package iomem_gpio_pkg;
  localparam logic [7:0] OFF_OUT     = 8'h00;
  localparam logic [7:0] OFF_DIR     = 8'h04;
  localparam logic [7:0] OFF_IN      = 8'h08;
  localparam logic [7:0] OFF_IRQ_EN  = 8'h0C;
  localparam logic [7:0] OFF_RISE    = 8'h10;
  localparam logic [7:0] OFF_FALL    = 8'h14;
  localparam logic [7:0] OFF_STATUS  = 8'h18;
  localparam logic [7:0] OFF_OUT_SET = 8'h1C;
  localparam logic [7:0] OFF_OUT_CLR = 8'h20;

  typedef enum logic [3:0] {
    REG_OUT, REG_DIR, REG_IN, REG_IRQ_EN, REG_RISE, REG_FALL,
    REG_STATUS, REG_OUT_SET, REG_OUT_CLR, REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_off(input logic [7:0] off);
    return off == OFF_OUT     ? REG_OUT     :
           off == OFF_DIR     ? REG_DIR     :
           off == OFF_IN      ? REG_IN      :
           off == OFF_IRQ_EN  ? REG_IRQ_EN  :
           off == OFF_RISE    ? REG_RISE    :
           off == OFF_FALL    ? REG_FALL    :
           off == OFF_STATUS  ? REG_STATUS  :
           off == OFF_OUT_SET ? REG_OUT_SET :
           off == OFF_OUT_CLR ? REG_OUT_CLR : REG_NONE;
  endfunction
endpackage

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: 2-flop pad synchroniser, plus stable-count debounce when IOMEM_GPIO_DEBOUNCE_EN is defined
module gpio_in_filter #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic pad_i,
  output logic in_o
);
  logic [1:0] sync_q, sync_d;
  // shift the pad value through two flops to resolve metastability
  always_comb sync_d = {sync_q[0], pad_i};
  // synchroniser state, cleared by reset
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) sync_q <= '0;
    else sync_q <= sync_d;
`ifdef IOMEM_GPIO_DEBOUNCE_EN
  logic [15:0] cnt_q, cnt_d;
  logic val_q, val_d;
  // accept a new level only after it differs for DEB_CYCLES consecutive cycles; any return restarts the count
  always_comb begin
    val_d = val_q;
    cnt_d = '0;
    if (sync_q[1] != val_q) begin
      cnt_d = (cnt_q == 16'(DEB_CYCLES - 1)) ? '0 : cnt_q + 16'd1;
      val_d = (cnt_q == 16'(DEB_CYCLES - 1)) ? sync_q[1] : val_q;
    end
  end
  // debounce state, cleared by reset
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      cnt_q <= '0;
      val_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      val_q <= val_d;
    end
  assign in_o = val_q;
`else
  logic unused_deb;
  assign unused_deb = ^DEB_CYCLES;
  assign in_o = sync_q[1];
`endif
endmodule

// File: rtl/iomem_gpio.sv
// iomem_gpio: iomem-bus GPIO block with edge interrupts; define IOMEM_GPIO_DEBOUNCE_EN to debounce inputs
module iomem_gpio
  import iomem_gpio_pkg::*;
#(
  parameter int         GPIO_W     = 8,
  parameter logic [7:0] BASE_SEL   = 8'h03,
  parameter int         DEB_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              iomem_valid_i,
  output logic              iomem_ready_o,
  input  logic [3:0]        iomem_wstrb_i,
  input  logic [31:0]       iomem_addr_i,
  input  logic [31:0]       iomem_wdata_i,
  output logic [31:0]       iomem_rdata_o,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe_o,
  output logic              irq_o
);
  logic [GPIO_W-1:0] out_q, out_d, dir_q, dir_d, en_q, en_d, rise_q, rise_d;
  logic [GPIO_W-1:0] fall_q, fall_d, status_q, status_d, prev_q, prev_d;
  logic [GPIO_W-1:0] in_w, m, wm, rval;
  logic              ready_q, ready_d, irq_q, irq_d, acc, wr;
  logic [31:0]       rdata_q, rdata_d, wmask;
  reg_sel_e          sel;
  logic              unused_ok;

  for (genvar i = 0; i < GPIO_W; i++) begin : g_in
    gpio_in_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filter (
      .clk_i (clk_i),
      .arst_i(arst_i),
      .pad_i (gpio_i[i]),
      .in_o  (in_w[i])
    );
  end

  assign acc       = iomem_valid_i & ~ready_q & (iomem_addr_i[31:24] == BASE_SEL);
  assign wr        = acc & |iomem_wstrb_i;
  assign sel       = decode_off(iomem_addr_i[7:0]);
  assign wmask     = {{8{iomem_wstrb_i[3]}}, {8{iomem_wstrb_i[2]}}, {8{iomem_wstrb_i[1]}}, {8{iomem_wstrb_i[0]}}};
  assign m         = wmask[GPIO_W-1:0];
  assign wm        = iomem_wdata_i[GPIO_W-1:0] & m;
  assign unused_ok = ^{iomem_addr_i[23:8], iomem_wdata_i, wmask};

  // read mux; write-only and unmapped offsets read as zero
  always_comb
    rval = sel == REG_OUT    ? out_q    :
           sel == REG_DIR    ? dir_q    :
           sel == REG_IN     ? in_w     :
           sel == REG_IRQ_EN ? en_q     :
           sel == REG_RISE   ? rise_q   :
           sel == REG_FALL   ? fall_q   :
           sel == REG_STATUS ? status_q : '0;

  // register updates, edge capture with set-over-clear, one-cycle ack and registered irq
  always_comb begin
    out_d    = wr && sel == REG_OUT     ? (out_q & ~m) | wm :
               wr && sel == REG_OUT_SET ? out_q | wm :
               wr && sel == REG_OUT_CLR ? out_q & ~wm : out_q;
    dir_d    = wr && sel == REG_DIR    ? (dir_q & ~m) | wm  : dir_q;
    en_d     = wr && sel == REG_IRQ_EN ? (en_q & ~m) | wm   : en_q;
    rise_d   = wr && sel == REG_RISE   ? (rise_q & ~m) | wm : rise_q;
    fall_d   = wr && sel == REG_FALL   ? (fall_q & ~m) | wm : fall_q;
    status_d = (status_q & ~(wr && sel == REG_STATUS ? wm : '0))
             | (in_w & ~prev_q & rise_q) | (~in_w & prev_q & fall_q);
    prev_d   = in_w;
    ready_d  = acc;
    rdata_d  = acc && !wr ? 32'(rval) : '0;
    irq_d    = |(status_q & en_q);
  end

  // state registers, all cleared by reset
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      out_q    <= '0;
      dir_q    <= '0;
      en_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      status_q <= '0;
      prev_q   <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      dir_q    <= dir_d;
      en_q     <= en_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      status_q <= status_d;
      prev_q   <= prev_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end

  assign iomem_ready_o = ready_q;
  assign iomem_rdata_o = rdata_q;
  assign gpio_o        = out_q;
  assign gpio_oe_o     = dir_q;
  assign irq_o         = irq_q;
endmodule

// File: tb/tb_iomem_gpio.sv
// tb_iomem_gpio: table-driven register checks plus hand sequences for edges, irq, reset and debounce
module tb_iomem_gpio;
  localparam logic [23:0] BASE = 24'h030000;
`ifdef IOMEM_GPIO_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  logic        clk_i = 1'b0, arst_i = 1'b1, iomem_valid_i = 1'b0;
  logic        iomem_ready_o, irq_o;
  logic [3:0]  iomem_wstrb_i = '0;
  logic [31:0] iomem_addr_i = '0, iomem_wdata_i = '0, iomem_rdata_o;
  logic [7:0]  gpio_i = '0, gpio_o, gpio_oe_o;
  int          checks = 0, errors = 0;

  typedef struct {
    logic        we;
    logic [7:0]  off;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  iomem_gpio #(.GPIO_W(8), .BASE_SEL(8'h03), .DEB_CYCLES(4)) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .iomem_valid_i(iomem_valid_i),
    .iomem_ready_o(iomem_ready_o),
    .iomem_wstrb_i(iomem_wstrb_i),
    .iomem_addr_i (iomem_addr_i),
    .iomem_wdata_i(iomem_wdata_i),
    .iomem_rdata_o(iomem_rdata_o),
    .gpio_i       (gpio_i),
    .gpio_o       (gpio_o),
    .gpio_oe_o    (gpio_oe_o),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
    int n = 0;
    iomem_valid_i = 1'b1;
    iomem_addr_i  = a;
    iomem_wdata_i = d;
    iomem_wstrb_i = s;
    do begin
      step(1);
      n++;
    end while (!iomem_ready_o && n < 20);
    r = iomem_rdata_o;
    chk("ready_latency", n, 1);
    iomem_valid_i = 1'b0;
    iomem_wstrb_i = '0;
    step(1);
    chk("ready_single", 32'(iomem_ready_o), 0);
    chk("rdata_idle", iomem_rdata_o, 0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] r;
    bus({BASE, off}, d, 4'hF, r);
  endtask

  task automatic rd(input string nm, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] r;
    bus({BASE, off}, 32'h0, 4'h0, r);
    chk(nm, r, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    logic       seen;
    tbl.push_back('{1'b0, 8'h00, 32'h0, 4'h0, 32'hA5});
    tbl.push_back('{1'b0, 8'h04, 32'h0, 4'h0, 32'h0F});
    tbl.push_back('{1'b1, 8'h00, 32'hF0, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 8'h1C, 32'h03, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 8'h20, 32'h80, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 8'h00, 32'h0, 4'h0, 32'h73});
    tbl.push_back('{1'b0, 8'h1C, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 8'h20, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b1, 8'h0C, 32'hFFFFFFFF, 4'h1, 32'h0});
    tbl.push_back('{1'b0, 8'h0C, 32'h0, 4'h0, 32'hFF});
    tbl.push_back('{1'b1, 8'h0C, 32'h0, 4'h2, 32'h0});
    tbl.push_back('{1'b0, 8'h0C, 32'h0, 4'h0, 32'hFF});
    tbl.push_back('{1'b1, 8'h0C, 32'h01, 4'h1, 32'h0});
    tbl.push_back('{1'b0, 8'h0C, 32'h0, 4'h0, 32'h01});
    tbl.push_back('{1'b1, 8'h24, 32'hFF, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 8'h24, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 8'h08, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 8'h18, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b1, 8'h04, 32'h123456C3, 4'hE, 32'h0});
    tbl.push_back('{1'b0, 8'h04, 32'h0, 4'h0, 32'h0F});

    step(2);
    chk("rst_ready", 32'(iomem_ready_o), 0);
    chk("rst_rdata", iomem_rdata_o, 0);
    chk("rst_gpio_o", 32'(gpio_o), 0);
    chk("rst_oe", 32'(gpio_oe_o), 0);
    chk("rst_irq", 32'(irq_o), 0);
    arst_i = 1'b0;
    step(1);

    wr(8'h00, 32'hA5);
    wr(8'h04, 32'h0F);
    chk("gpio_o_a5", 32'(gpio_o), 32'hA5);
    chk("gpio_oe_0f", 32'(gpio_oe_o), 32'h0F);

    for (int k = 0; k < tbl.size(); k++) begin
      logic [31:0] r;
      bus({BASE, tbl[k].off}, tbl[k].data, tbl[k].strb, r);
      if (!tbl[k].we) chk($sformatf("tbl%0d_rd_%02h", k, tbl[k].off), r, tbl[k].exp);
    end
    chk("gpio_o_73", 32'(gpio_o), 32'h73);
    chk("gpio_oe_kept", 32'(gpio_oe_o), 32'h0F);

    wr(8'h10, 32'h01);
    gpio_i[0] = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      step(1);
      if (k == LAT + 1) chk("irq_not_yet", 32'(irq_o), 0);
      if (k == LAT + 2) chk("irq_rise", 32'(irq_o), 1);
    end
    rd("status_rise", 8'h18, 32'h01);
    wr(8'h18, 32'h01);
    chk("irq_cleared", 32'(irq_o), 0);
    rd("status_w1c", 8'h18, 32'h00);

    gpio_i[0] = 1'b0;
    step(LAT + 3);
    gpio_i[0] = 1'b1;
    step(LAT);
    wr(8'h18, 32'h01);
    rd("status_set_wins", 8'h18, 32'h01);
    chk("irq_after_coincide", 32'(irq_o), 1);

    gpio_i[7] = 1'b1;
    step(LAT);
    rd("in_latency", 8'h08, 32'h81);

    pat = '0;
    iomem_valid_i = 1'b1;
    iomem_addr_i  = {BASE, 8'h00};
    iomem_wstrb_i = 4'h0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      pat = {pat[2:0], iomem_ready_o};
    end
    iomem_valid_i = 1'b0;
    step(1);
    chk("ready_alternates", 32'(pat), 32'hA);

    iomem_valid_i = 1'b1;
    iomem_addr_i  = {BASE, 8'h00};
    iomem_wdata_i = 32'hFF;
    iomem_wstrb_i = 4'hF;
    #2 arst_i = 1'b1;
    step(1);
    chk("abort_ready", 32'(iomem_ready_o), 0);
    chk("abort_gpio_o", 32'(gpio_o), 0);
    chk("abort_oe", 32'(gpio_oe_o), 0);
    chk("abort_irq", 32'(irq_o), 0);
    chk("abort_rdata", iomem_rdata_o, 0);
    iomem_valid_i = 1'b0;
    iomem_wstrb_i = '0;
    arst_i = 1'b0;
    wr(8'h10, 32'h01);
    step(LAT + 1);
    rd("status_reset_edge", 8'h18, 32'h01);
    rd("out_after_reset", 8'h00, 32'h00);
    wr(8'h00, 32'h3C);
    rd("out_after_reset_wr", 8'h00, 32'h3C);
    rd("in_after_reset", 8'h08, 32'h81);

    seen = 1'b0;
    iomem_valid_i = 1'b1;
    iomem_addr_i  = 32'h04000000;
    iomem_wdata_i = 32'hFF;
    iomem_wstrb_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step(1);
      seen |= iomem_ready_o;
    end
    iomem_valid_i = 1'b0;
    iomem_wstrb_i = '0;
    step(1);
    chk("foreign_base_no_ready", 32'(seen), 0);
    rd("foreign_base_no_write", 8'h00, 32'h3C);

`ifdef IOMEM_GPIO_DEBOUNCE_EN
    gpio_i[1] = 1'b1;
    step(3);
    gpio_i[1] = 1'b0;
    step(3);
    rd("deb_short_pulse", 8'h08, 32'h81);
    step(10);
    gpio_i[1] = 1'b1;
    step(6);
    gpio_i[1] = 1'b0;
    rd("deb_long_pulse", 8'h08, 32'h83);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
